// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives one cycle of J/K excitation into an external JK bank, then
// verifies the Q readback and retries. Build macro JKDRV_TOGGLE_EN selects toggle excitation.
module jk_bank_driver #(
   parameter int WIDTH     = 4,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CHECK
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] target, target_nx;
   logic [WIDTH-1:0] j_nx, k_nx;
   logic [WIDTH-1:0] exc_tgt, diff, j_calc, k_calc;
   logic [CW-1:0]    retry_cnt, retry_nx;
   logic             done_nx, err_nx;

   assign tgt_ready = (state == IDLE);
   assign busy      = (state == DRIVE) || (state == CHECK);

   // First attempt excites toward the incoming word; retries use the registered target.
   assign exc_tgt = (state == IDLE) ? tgt_data : target;
   assign diff    = q_in ^ exc_tgt;

`ifdef JKDRV_TOGGLE_EN
   assign j_calc = diff;
   assign k_calc = diff;
`else
   assign j_calc = diff & exc_tgt;
   assign k_calc = diff & ~exc_tgt;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_nx  = state;
      target_nx = target;
      retry_nx  = retry_cnt;
      j_nx      = '0;
      k_nx      = '0;
      done_nx   = 1'b0;
      err_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (tgt_valid && tgt_ready) begin
               target_nx = tgt_data;
               retry_nx  = '0;
               j_nx      = j_calc;
               k_nx      = k_calc;
               state_nx  = DRIVE;
            end
         end
         DRIVE: begin
            state_nx = CHECK;
         end
         CHECK: begin
            if (q_in == target) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else if (retry_cnt < CW'(MAX_RETRY)) begin
               retry_nx = retry_cnt + CW'(1);
               j_nx     = j_calc;
               k_nx     = k_calc;
               state_nx = DRIVE;
            end else begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         target    <= '0;
         retry_cnt <= '0;
         j_out     <= '0;
         k_out     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         target    <= target_nx;
         retry_cnt <= retry_nx;
         j_out     <= j_nx;
         k_out     <= k_nx;
         done      <= done_nx;
         err       <= err_nx;
      end
   end

endmodule
